uart_tx_sink: RTL and testbench

Simulation-side and synthesizable UART receiver that consumes the serial `Tx` line driven by `riscv_top`. It is the counterpart to the stimulus the testbench drives into the CPU: it decodes 8N1 frames into bytes and buffers them in a small FIFO, so benches and on-board logic can check program output. It sits outside `riscv_top`, on the top-level `Tx` net.

---
 rtl/uart_tx_sink.sv | 245 ++++++++++++++++++++++++
 tb/tb_uart_tx_sink.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sink.sv
// -----------------------------------------------------------------------------
// uart_tx_sink
//
// Receives 8N1 serial frames from the riscv_top Tx net, decodes them into
// bytes and buffers them in a small first-word-fall-through FIFO. Benches and
// on-board logic pop received program output from the FIFO.
//
// Parameters:
//   SYS_CLK_FREQ     clk frequency in Hz
//   BAUD_RATE        line rate in bit/s; SYS_CLK_FREQ / BAUD_RATE must be >= 4
//   FIFO_DEPTH_LOG2  FIFO holds 2**FIFO_DEPTH_LOG2 bytes (>= 1)
//
// Ports:
//   clk         system clock, single domain
//   rst         synchronous active-high reset
//   rx          serial line, idle high, asynchronous to clk
//   rd_en       pop the head byte (ignored while empty)
//   rd_data     head byte, valid while empty = 0
//   empty       FIFO empty
//   full        FIFO full
//   overflow    sticky: a received byte was dropped because the FIFO was full
//   frame_err   sticky: a stop bit was sampled low
//   byte_count  bytes accepted into the FIFO, wraps modulo 2^32
//
// Build option:
//   UART_TX_SINK_DISPLAY_EN  when defined, accepted bytes are echoed with
//                            $write and framing errors are reported with
//                            $display (simulation only; hardware unchanged).
// -----------------------------------------------------------------------------
module uart_tx_sink #(
  parameter int SYS_CLK_FREQ    = 100000000,
  parameter int BAUD_RATE       = 115200,
  parameter int FIFO_DEPTH_LOG2 = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  input  logic        rd_en,
  output logic [7:0]  rd_data,
  output logic        empty,
  output logic        full,
  output logic        overflow,
  output logic        frame_err,
  output logic [31:0] byte_count
);

  localparam int CPB   = SYS_CLK_FREQ / BAUD_RATE;
  localparam int CW    = $clog2(CPB) + 1;
  localparam int AW    = FIFO_DEPTH_LOG2;
  localparam int DEPTH = 1 << AW;

  localparam logic [CW-1:0] FULL_BIT_M1 = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_BIT_M1 = CW'(CPB / 2 - 1);

  generate
    if (CPB < 4) begin : g_cpb_check
      $error("uart_tx_sink: SYS_CLK_FREQ / BAUD_RATE must be at least 4");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizer: both stages idle high so reset never looks like a start
  // ---------------------------------------------------------------------------
  logic rx_meta;
  logic rxs;

  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0]    bit_cnt, bit_cnt_d;
  logic [7:0]    shreg, shreg_d;
  logic          push;
  logic          ferr_set;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave a value held and infer a latch.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    bit_cnt_d = bit_cnt;
    shreg_d   = shreg;
    push      = 1'b0;
    ferr_set  = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (!rxs) begin
          state_d   = S_START;
          // The cycle that detects the low level counts as the first of the
          // half-bit wait, which puts every later sample at mid-bit.
          cnt_d     = CW'(1);
          bit_cnt_d = 3'd0;
        end
      end

      S_START: begin
        if (cnt == HALF_BIT_M1) begin
          cnt_d   = '0;
          state_d = rxs ? S_IDLE : S_DATA;  // high at mid-bit: glitch
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end

      S_DATA: begin
        if (cnt == FULL_BIT_M1) begin
          cnt_d     = '0;
          shreg_d   = {rxs, shreg[7:1]};    // LSB arrives first
          bit_cnt_d = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            state_d = S_STOP;
          end
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end

      S_STOP: begin
        if (cnt == FULL_BIT_M1) begin
          cnt_d = '0;
          if (rxs) begin
            push    = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_set = 1'b1;
            state_d  = S_BREAK;
          end
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end

      S_BREAK: begin
        // A line held low must return high before another start is accepted.
        if (rxs) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_cnt <= 3'd0;
      shreg   <= 8'h00;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      bit_cnt <= bit_cnt_d;
      shreg   <= shreg_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO: pointers carry one extra MSB to tell full from empty
  // ---------------------------------------------------------------------------
  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_pop;
  logic        do_push;
  logic        drop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign do_pop  = rd_en && !empty;
  // A pop in the same cycle frees the slot the push needs, even when full.
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;

  assign rd_data = mem[rd_ptr[AW-1:0]];

  // NOTE: the storage array has no reset; only the pointers define which
  // entries are valid, so clearing the contents would add logic for nothing.
  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      mem[wr_ptr[AW-1:0]] <= shreg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow   <= 1'b0;
      frame_err  <= 1'b0;
      byte_count <= 32'd0;
    end else begin
      if (do_push) begin
        wr_ptr     <= wr_ptr + (AW+1)'(1);
        byte_count <= byte_count + 32'd1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
      if (drop) begin
        overflow <= 1'b1;
      end
      if (ferr_set) begin
        frame_err <= 1'b1;
      end
    end
  end

`ifdef UART_TX_SINK_DISPLAY_EN
  always @(posedge clk) begin
    if (!rst && do_push) begin
      $write("%c", shreg);
    end
    if (!rst && ferr_set) begin
      $display("uart_tx_sink: frame error at %t", $time);
    end
  end
`else
`endif

endmodule

// File: tb/tb_uart_tx_sink.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_sink
//
// Directed bench for uart_tx_sink with CPB = 16 and a 4-entry FIFO. Frames are
// driven one clk at a time from the falling clock edge; outputs are observed
// at falling edges, away from the active edge.
// -----------------------------------------------------------------------------
module tb_uart_tx_sink;

  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic        rd_en;
  logic [7:0]  rd_data;
  logic        empty;
  logic        full;
  logic        overflow;
  logic        frame_err;
  logic [31:0] byte_count;

  int vectors     = 0;
  int miscompares = 0;

  uart_tx_sink #(
    .SYS_CLK_FREQ   (16),
    .BAUD_RATE      (1),
    .FIFO_DEPTH_LOG2(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .frame_err (frame_err),
    .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one 10-bit frame, one bit per CPB cycles, starting at a falling
  // clock edge. pop_at > 0 makes rd_en sampled on that rising edge (edges are
  // counted from the start-bit drive). rst_at >= 0 asserts rst for two edges.
  // fall_edge reports the first edge after which empty was seen low.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                            input int pop_at, input int rst_at,
                            output int fall_edge);
    logic [9:0] bits;
    bits      = {stop_bit, data, 1'b0};
    fall_edge = -1;
    for (int c = 0; c < 10 * CPB; c++) begin
      @(negedge clk);
      if (fall_edge < 0 && c > 0 && !empty) fall_edge = c;
      rx    = bits[c / CPB];
      rd_en = (c == pop_at - 1);
      rst   = (rst_at >= 0) && (c >= rst_at) && (c < rst_at + 2);
    end
  endtask

  task automatic send(input logic [7:0] data);
    int f;
    send_frame(data, 1'b1, 0, -1, f);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx = 1'b1;
    end
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    check({tag, "_not_empty"}, {31'd0, empty}, 32'd0);
    check(tag, {24'd0, rd_data}, {24'd0, exp});
    @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  initial begin
    int fall;

    rst   = 1'b1;
    rx    = 1'b1;
    rd_en = 1'b0;

    // Reset state
    repeat (5) @(negedge clk);
    rst = 1'b0;
    check("rst_empty",      {31'd0, empty},     32'd1);
    check("rst_full",       {31'd0, full},      32'd0);
    check("rst_overflow",   {31'd0, overflow},  32'd0);
    check("rst_frame_err",  {31'd0, frame_err}, 32'd0);
    check("rst_byte_count", byte_count,         32'd0);
    idle(8);

    // Single frame 0x41: push due 2 + 8 + 144 = 154 edges after start, +/-1
    send_frame(8'h41, 1'b1, 0, -1, fall);
    check("single_fall_in_window", {31'd0, (fall >= 153 && fall <= 155)}, 32'd1);
    check("single_byte_count", byte_count, 32'd1);
    pop_check("single_rd_data", 8'h41);
    check("single_empty_after_pop", {31'd0, empty}, 32'd1);

    // 3-cycle glitch must not start a frame
    repeat (3) begin
      @(negedge clk);
      rx = 1'b0;
    end
    idle(40);
    check("glitch_empty",      {31'd0, empty}, 32'd1);
    check("glitch_byte_count", byte_count,     32'd1);

    // Back-to-back frames
    send(8'h00);
    send(8'hFF);
    send(8'h55);
    check("b2b_byte_count", byte_count, 32'd4);
    pop_check("b2b_0", 8'h00);
    pop_check("b2b_1", 8'hFF);
    pop_check("b2b_2", 8'h55);
    check("b2b_empty", {31'd0, empty}, 32'd1);

    // Overflow: fifth byte dropped
    send(8'h01);
    send(8'h02);
    send(8'h03);
    send(8'h04);
    check("ovf_full_after_4",  {31'd0, full},     32'd1);
    check("ovf_clear_after_4", {31'd0, overflow}, 32'd0);
    send(8'h05);
    check("ovf_set",        {31'd0, overflow}, 32'd1);
    check("ovf_full",       {31'd0, full},     32'd1);
    check("ovf_byte_count", byte_count,        32'd8);
    pop_check("ovf_0", 8'h01);
    pop_check("ovf_1", 8'h02);
    pop_check("ovf_2", 8'h03);
    pop_check("ovf_3", 8'h04);
    check("ovf_empty", {31'd0, empty}, 32'd1);

    // Reset clears sticky overflow and the counter
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst2_overflow",   {31'd0, overflow}, 32'd0);
    check("rst2_byte_count", byte_count,        32'd0);
    idle(8);

    // Push and pop in the same cycle while full
    send(8'h01);
    send(8'h02);
    send(8'h03);
    send(8'h04);
    send_frame(8'h05, 1'b1, 154, -1, fall);
    check("pp_overflow",   {31'd0, overflow}, 32'd0);
    check("pp_full",       {31'd0, full},     32'd1);
    check("pp_byte_count", byte_count,        32'd5);
    pop_check("pp_0", 8'h02);
    pop_check("pp_1", 8'h03);
    pop_check("pp_2", 8'h04);
    pop_check("pp_3", 8'h05);
    check("pp_empty", {31'd0, empty}, 32'd1);

    // Framing error followed by a held-low line, then a good frame
    send_frame(8'h3C, 1'b0, 0, -1, fall);
    repeat (40) begin
      @(negedge clk);
      rx = 1'b0;
    end
    idle(20);
    send(8'h7E);
    check("ferr_set",        {31'd0, frame_err}, 32'd1);
    check("ferr_byte_count", byte_count,         32'd6);
    pop_check("ferr_rd_data", 8'h7E);
    check("ferr_empty", {31'd0, empty}, 32'd1);

    // Reset during data bit 4 of 0x99 (bit 4 spans cycles 80..95)
    send(8'h00);
    send_frame(8'h99, 1'b1, 0, 86, fall);
    check("midrst_empty",      {31'd0, empty},     32'd1);
    check("midrst_byte_count", byte_count,         32'd0);
    check("midrst_frame_err",  {31'd0, frame_err}, 32'd0);
    // Let any frame decoded from the tail of 0x99 finish, then drain it.
    idle(300);
    repeat (4) begin
      @(negedge clk);
      rd_en = 1'b1;
    end
    @(negedge clk);
    rd_en = 1'b0;
    check("midrst_drained", {31'd0, empty}, 32'd1);
    send(8'h12);
    pop_check("midrst_next", 8'h12);
    check("midrst_next_empty", {31'd0, empty}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
